// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: address/count
// width helpers, default almost-full/almost-empty margins, and the bit
// positions of the sticky error flags for the downstream status register.
package sync_fifo_param_pkg;

  // Default distance of the almost-full threshold below DEPTH.
  localparam int DEF_AF_MARGIN = 4;
  // Default almost-empty threshold.
  localparam int DEF_AE_LEVEL  = 4;

  // Error-flag bit positions within the status word.
  localparam int ERR_OVERFLOW_BIT  = 0;
  localparam int ERR_UNDERFLOW_BIT = 1;
  localparam int ERR_BITS          = 2;

  // Pointer width for a power-of-two depth.
  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one bit wider than the pointer so DEPTH is representable.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Decoded request/accept qualifiers for one clock edge.
  typedef struct packed {
    logic wr_req;
    logic rd_req;
    logic wr_ok;
    logic rd_ok;
  } fifo_xfer_t;

endpackage : sync_fifo_param_pkg

// File: rtl/sync_fifo_param_dp_ram.sv
// Simple dual-port RAM, WIDTH x DEPTH: synchronous write port and a
// synchronous registered read port with read enable. Kept as its own module
// so a compiled memory macro can replace it without touching FIFO control.
module fifo_dp_ram
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  localparam int AW   = fifo_aw(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store data at the write address when enabled.
  // NOTE: the storage array has no reset; resetting it would prevent RAM
  // inference and stored contents are meaningless once the pointers reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered output, updated only on an enabled read.
  // NOTE: non-blocking assignments here mean a same-edge write to i_raddr is
  // not visible to this read; the old word is returned (read-first).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule : fifo_dp_ram

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with simultaneous read/write, occupancy
// count, programmable almost-full/almost-empty flags and sticky
// overflow/underflow error flags with a synchronous clear.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         DIN,
  input  logic                     WE_N,
  input  logic                     OE_N,
  input  logic                     CLR_ERR,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int FIFO_AW = fifo_aw(DEPTH);
  localparam int FIFO_CW = fifo_cw(DEPTH);

  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_CW-1:0]  r_count;
  logic [ERR_BITS-1:0] r_err;

  fifo_xfer_t          w_xfer;
  logic [FIFO_CW-1:0]  w_count_nxt;
  logic [ERR_BITS-1:0] w_err_set;
  logic                w_full;
  logic                w_empty;
  logic                w_ram_we;

  // Status flags are pure decodes of the registered occupancy.
  assign w_full       = (r_count == FIFO_CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign FULL         = w_full;
  assign EMPTY        = w_empty;
  assign ALMOST_FULL  = (r_count >= FIFO_CW'(AF_LEVEL));
  assign ALMOST_EMPTY = (r_count <= FIFO_CW'(AE_LEVEL));
  assign COUNT        = r_count;
  assign OVERFLOW     = r_err[ERR_OVERFLOW_BIT];
  assign UNDERFLOW    = r_err[ERR_UNDERFLOW_BIT];

  // Request decode: a read needs data; a write needs space or a same-cycle read.
  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_xfer        = '0;
    w_err_set     = '0;
    w_xfer.wr_req = !WE_N;
    w_xfer.rd_req = !OE_N;
    w_xfer.rd_ok  = w_xfer.rd_req && !w_empty;
    w_xfer.wr_ok  = w_xfer.wr_req && (!w_full || w_xfer.rd_ok);
    w_err_set[ERR_OVERFLOW_BIT]  = w_xfer.wr_req && !w_xfer.wr_ok;
    w_err_set[ERR_UNDERFLOW_BIT] = w_xfer.rd_req && !w_xfer.rd_ok;
  end

  // Next occupancy: net change of accepted writes and reads.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_xfer.wr_ok, w_xfer.rd_ok})
      2'b10:   w_count_nxt = r_count + FIFO_CW'(1);
      2'b01:   w_count_nxt = r_count - FIFO_CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // A write coinciding with an asserted reset must not land in the RAM.
  assign w_ram_we = w_xfer.wr_ok && !RST;

  // Pointer and occupancy registers; pointers wrap by binary rollover.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_xfer.wr_ok) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_xfer.rd_ok) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Sticky error flags: a new error outranks a same-cycle clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= '0;
    end else begin
      r_err <= w_err_set | (CLR_ERR ? '0 : r_err);
    end
  end

  fifo_dp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (DIN),
    .i_re    (w_xfer.rd_ok),
    .i_raddr (r_rd_ptr),
    .o_rdata (DOUT)
  );

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16, WIDTH=8, AF=12, AE=4).
// Read data expectations go into a scoreboard queue tagged with the cycle in
// which DOUT must show them; a monitor pops and compares on the falling edge.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;
  localparam int CW = $clog2(D) + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [W-1:0]  DIN = '0;
  logic          WE_N = 1'b1;
  logic          OE_N = 1'b1;
  logic          CLR_ERR = 1'b0;
  logic [W-1:0]  DOUT;
  logic          FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [CW-1:0] COUNT;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t q_exp[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  sync_fifo_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .DIN          (DIN),
    .WE_N         (WE_N),
    .OE_N         (OE_N),
    .CLR_ERR      (CLR_ERR),
    .DOUT         (DOUT),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .COUNT        (COUNT),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: DOUT is due in the cycle following the accepting edge.
  always @(negedge CLK) begin
    if (q_exp.size() > 0 && q_exp[0].due == cyc) begin
      exp_t e;
      e = q_exp.pop_front();
      check("dout", 32'(DOUT), 32'(e.data));
    end
  end

  // One clock of stimulus; exp_rd says whether the read should be accepted.
  task automatic op(input logic we, input logic re, input logic [W-1:0] din,
                    input logic clr, input logic exp_rd, input logic [W-1:0] exp_data);
    WE_N    = !we;
    OE_N    = !re;
    DIN     = din;
    CLR_ERR = clr;
    @(posedge CLK);
    #1;
    if (exp_rd) q_exp.push_back('{data: exp_data, due: cyc});
    WE_N    = 1'b1;
    OE_N    = 1'b1;
    CLR_ERR = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(COUNT), 0);
    check({tag, "_empty"}, 32'(EMPTY), 1);
    check({tag, "_full"},  32'(FULL), 0);
    check({tag, "_ae"},    32'(ALMOST_EMPTY), 1);
    check({tag, "_af"},    32'(ALMOST_FULL), 0);
    check({tag, "_ovf"},   32'(OVERFLOW), 0);
    check({tag, "_udf"},   32'(UNDERFLOW), 0);
    check({tag, "_dout"},  32'(DOUT), 0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Fill 0x00..0x0F; flags track the hand-computed thresholds.
    for (int i = 0; i < D; i++) begin
      op(1'b1, 1'b0, W'(i), 1'b0, 1'b0, '0);
      check("fill_count", 32'(COUNT), 32'(i + 1));
      check("fill_ae", 32'(ALMOST_EMPTY), (i + 1 <= 4) ? 1 : 0);
      check("fill_af", 32'(ALMOST_FULL), (i + 1 >= 12) ? 1 : 0);
    end
    check("full_after_fill", 32'(FULL), 1);
    check("ovf_after_fill", 32'(OVERFLOW), 0);

    // Overflow: write while full with no read; data dropped.
    op(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, '0);
    check("ovf_set", 32'(OVERFLOW), 1);
    check("ovf_count", 32'(COUNT), 16);

    // Drain: 0x00..0x0F, never 0xAA.
    for (int i = 0; i < D; i++) begin
      op(1'b0, 1'b1, '0, 1'b0, 1'b1, W'(i));
    end
    check("drain_empty", 32'(EMPTY), 1);
    check("drain_count", 32'(COUNT), 0);

    // Underflow: read while empty; DOUT holds its last value.
    op(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
    #5;
    check("udf_set", 32'(UNDERFLOW), 1);
    check("udf_dout_hold", 32'(DOUT), 32'h0F);
    check("udf_count", 32'(COUNT), 0);

    // Clear both sticky flags.
    op(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("clr_ovf", 32'(OVERFLOW), 0);
    check("clr_udf", 32'(UNDERFLOW), 0);

    // A new error in the clearing cycle wins.
    op(1'b0, 1'b1, '0, 1'b1, 1'b0, '0);
    check("clr_vs_new_udf", 32'(UNDERFLOW), 1);
    check("clr_vs_new_ovf", 32'(OVERFLOW), 0);
    op(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("clr2_udf", 32'(UNDERFLOW), 0);

    // Refill with 0x10..0x1F, then write+read at full.
    for (int i = 0; i < D; i++) begin
      op(1'b1, 1'b0, W'(8'h10 + i), 1'b0, 1'b0, '0);
    end
    op(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 8'h10);
    check("full_rw_count", 32'(COUNT), 16);
    check("full_rw_full", 32'(FULL), 1);
    check("full_rw_ovf", 32'(OVERFLOW), 0);
    for (int i = 1; i < D; i++) begin
      op(1'b0, 1'b1, '0, 1'b0, 1'b1, W'(8'h10 + i));
    end
    op(1'b0, 1'b1, '0, 1'b0, 1'b1, 8'h55);
    check("full_rw_drained", 32'(COUNT), 0);

    // Write+read at empty: write accepted, read rejected.
    op(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, '0);
    check("empty_rw_count", 32'(COUNT), 1);
    check("empty_rw_udf", 32'(UNDERFLOW), 1);
    op(1'b0, 1'b1, '0, 1'b1, 1'b1, 8'h77);
    check("empty_rw_clr", 32'(UNDERFLOW), 0);

    // Wrap-around: pre-load 3, then 40 paired write/read cycles.
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 1'b0, W'(8'h80 + i), 1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 40; i++) begin
      op(1'b1, 1'b1, W'(8'h83 + i), 1'b0, 1'b1, W'(8'h80 + i));
      check("wrap_count", 32'(COUNT), 3);
    end

    // Bring occupancy to 9, then assert reset between edges.
    for (int i = 0; i < 6; i++) begin
      op(1'b1, 1'b0, W'(8'hC0 + i), 1'b0, 1'b0, '0);
    end
    check("pre_reset_count", 32'(COUNT), 9);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    op(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, '0);
    check("post_rst_count", 32'(COUNT), 1);
    op(1'b0, 1'b1, '0, 1'b0, 1'b1, 8'h3C);
    check("post_rst_empty", 32'(EMPTY), 1);

    // Let the monitor consume the last expectation.
    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard_drained", 32'(q_exp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo_param
